// File: rtl/apb4_master.sv
// APB4 master bridge: takes one request at a time from a valid/ready port and runs it
// as a SETUP/ACCESS transfer. The response is held until it is consumed.
module apb4_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_write,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    input  logic [2:0]              req_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_slverr,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [2:0]              pprot,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam bit TO_EN      = (TIMEOUT > 0);
    localparam int CNT_WIDTH  = TO_EN ? (($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1)) : 1;
    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TO_EN ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [2:0]              pprot_q, pprot_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_slverr_q, rsp_slverr_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    timeout_hit;

    // The final waiting cycle is the one where the count is about to reach TIMEOUT.
    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        paddr_d       = paddr_q;
        pprot_d       = pprot_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d  = SETUP;
                    paddr_d  = req_addr;
                    pprot_d  = req_prot;
                    pwrite_d = req_write;
                    pwdata_d = req_write ? req_wdata : '0;
                    pstrb_d  = req_write ? req_strb : '0;
                    cnt_d    = '0;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (pready) begin
                    state_d       = RESP;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                    rsp_slverr_d  = pslverr;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d       = RESP;
                    rsp_rdata_d   = '0;
                    rsp_slverr_d  = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!presetn) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pprot_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pprot_q       <= pprot_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign psel        = (state_q == SETUP) || (state_q == ACCESS);
    assign penable     = (state_q == ACCESS);
    assign paddr       = paddr_q;
    assign pprot       = pprot_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = rsp_slverr_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb4_master.sv
// Directed bench for apb4_master (TIMEOUT=4): outputs are sampled 1ns after each rising
// edge and new inputs are applied at that same point.
module tb_apb4_master;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr, pwdata, prdata;
    logic [2:0]  pprot;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [3:0]  pstrb;

    int n_checks = 0;
    int n_fail   = 0;

    apb4_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] strb, input logic [2:0] prot);
        req_valid = 1'b1;
        req_addr  = addr;
        req_write = wr;
        req_wdata = wd;
        req_strb  = strb;
        req_prot  = prot;
    endtask

    task automatic scramble_req();
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFF0;
        req_write = ~req_write;
        req_wdata = 32'h0BAD_F00D;
        req_strb  = 4'h5;
        req_prot  = 3'b010;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        presetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
        req_wdata = '0; req_strb = '0; req_prot = '0; rsp_ready = 1'b1;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;

        // Reset state
        cyc(); cyc();
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwrite", pwrite, 0);
        presetn = 1'b1;
        cyc();
        check("rst_req_ready", req_ready, 1);

        // Zero-wait write: SETUP at N+1, ACCESS at N+2, response at N+3, ready at N+4
        issue(32'h0000_0008, 1'b1, 32'hA5A5_5A5A, 4'hF, 3'b101);
        pready = 1'b1; prdata = 32'hDEAD_BEEF;
        cyc();
        scramble_req();
        check("wr_setup_psel", psel, 1);
        check("wr_setup_penable", penable, 0);
        check("wr_setup_req_ready", req_ready, 0);
        check("wr_setup_paddr", paddr, 32'h0000_0008);
        check("wr_setup_pwdata", pwdata, 32'hA5A5_5A5A);
        check("wr_setup_pstrb", pstrb, 4'hF);
        check("wr_setup_pwrite", pwrite, 1);
        check("wr_setup_pprot", pprot, 3'b101);
        cyc();
        check("wr_access_psel", psel, 1);
        check("wr_access_penable", penable, 1);
        check("wr_access_paddr", paddr, 32'h0000_0008);
        check("wr_access_pwdata", pwdata, 32'hA5A5_5A5A);
        cyc();
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_psel", psel, 0);
        check("wr_rsp_penable", penable, 0);
        check("wr_rsp_slverr", rsp_slverr, 0);
        check("wr_rsp_timeout", rsp_timeout, 0);
        check("wr_rsp_rdata", rsp_rdata, 0);
        cyc();
        check("wr_next_req_ready", req_ready, 1);
        check("wr_next_rsp_valid", rsp_valid, 0);

        // Wait-state read: 3 low-pready ACCESS cycles, completes on the 4th (also the
        // cycle where the TIMEOUT=4 counter would fire, so pready must win)
        pready = 1'b0; pslverr = 1'b1;
        issue(32'h0000_000C, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b000);
        cyc();
        scramble_req();
        check("rd_setup_paddr", paddr, 32'h0000_000C);
        check("rd_setup_pstrb", pstrb, 0);
        check("rd_setup_pwdata", pwdata, 0);
        check("rd_setup_pwrite", pwrite, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("rd_wait_psel", psel, 1);
            check("rd_wait_penable", penable, 1);
            check("rd_wait_paddr", paddr, 32'h0000_000C);
            check("rd_wait_pstrb", pstrb, 0);
        end
        cyc();
        check("rd_acc4_psel", psel, 1);
        check("rd_acc4_paddr", paddr, 32'h0000_000C);
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h1234_5678;
        cyc();
        prdata = 32'h0;
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
        check("rd_rsp_slverr", rsp_slverr, 0);
        check("rd_rsp_timeout", rsp_timeout, 0);
        cyc();
        check("rd_next_req_ready", req_ready, 1);

        // Slave error on a write, then 10 cycles of response backpressure
        pready = 1'b1; pslverr = 1'b1; rsp_ready = 1'b0;
        issue(32'h0000_0010, 1'b1, 32'h0000_00FF, 4'h1, 3'b001);
        cyc();
        scramble_req();
        cyc();
        check("err_access_penable", penable, 1);
        cyc();
        pslverr = 1'b0; prdata = 32'h7777_7777;
        issue(32'h0000_0020, 1'b0, 32'h0, 4'h0, 3'b011);
        for (int i = 0; i < 10; i++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_slverr", rsp_slverr, 1);
            check("bp_rsp_timeout", rsp_timeout, 0);
            check("bp_rsp_rdata", rsp_rdata, 0);
            check("bp_req_ready", req_ready, 0);
            check("bp_psel", psel, 0);
            pready = ~pready;
            cyc();
        end
        check("bp_end_rsp_valid", rsp_valid, 1);
        rsp_ready = 1'b1; pready = 1'b0;
        cyc();
        check("bp_release_req_ready", req_ready, 1);
        check("bp_release_rsp_valid", rsp_valid, 0);

        // Queued request accepted now; slave never answers -> timeout after 4 ACCESS cycles
        cyc();
        scramble_req();
        check("to_setup_psel", psel, 1);
        check("to_setup_paddr", paddr, 32'h0000_0020);
        check("to_setup_pprot", pprot, 3'b011);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("to_wait_psel", psel, 1);
            check("to_wait_penable", penable, 1);
            check("to_wait_rsp_valid", rsp_valid, 0);
        end
        cyc();
        check("to_psel_drop", psel, 0);
        check("to_penable_drop", penable, 0);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_slverr", rsp_slverr, 1);
        check("to_rsp_timeout", rsp_timeout, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        cyc();
        check("to_next_req_ready", req_ready, 1);

        // Reset during a wait state abandons the transfer
        issue(32'h0000_0030, 1'b1, 32'hCAFE_0001, 4'hC, 3'b111);
        cyc();
        scramble_req();
        cyc();
        check("rip_access_penable", penable, 1);
        presetn = 1'b0;
        cyc();
        check("rip_psel", psel, 0);
        check("rip_penable", penable, 0);
        check("rip_paddr", paddr, 0);
        check("rip_pwdata", pwdata, 0);
        check("rip_pstrb", pstrb, 0);
        check("rip_pprot", pprot, 0);
        check("rip_pwrite", pwrite, 0);
        check("rip_rsp_valid", rsp_valid, 0);
        check("rip_rsp_slverr", rsp_slverr, 0);
        presetn = 1'b1;
        cyc();
        check("rip_release_req_ready", req_ready, 1);
        check("rip_release_rsp_valid", rsp_valid, 0);
        check("rip_release_psel", psel, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
